pmac_verify: RTL
================

# pmac_verify

Initiator-side wrapper that drives the `pmac` engine and checks a received tag. It accepts a verify request carrying a beat count and an expected 128-bit tag, issues the length request to `pmac`, and forwards the data stream to it. It then collects the computed MAC, compares it against the expected tag, and returns a single pass/fail result. It sits between the shell-side integrity-check logic (producer of data and received tags) and one `pmac` instance.

## Interface
Parameters:
- `DATA_WIDTH`, 512, stream beat width; must match the attached `pmac`.
- `TAG_WIDTH`, 128, MAC/tag width; fixed to 128.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `vreq_val` in 1, `vreq_rdy` out 1: verify request handshake.
- `vreq_len` in 16: number of data beats.
- `vreq_tag` in 128: expected tag.
- `in_data` in DATA_WIDTH, `in_val` in 1, `in_rdy` out 1: upstream data stream.
- `pmac_req_val` out 1, `pmac_req_rdy` in 1, `pmac_req_len` out 16: engine request.
- `pmac_data` out DATA_WIDTH, `pmac_data_val` out 1, `pmac_data_rdy` in 1: engine stream.
- `pmac_tag` in 128, `pmac_tag_val` in 1, `pmac_tag_rdy` out 1: engine result.
- `res_val` out 1, `res_rdy` in 1: result handshake.
- `res_ok` out 1: 1 means the tag matched.
- `res_len_err` out 1: 1 means the request had zero length.
- `err_cnt` out 32: present only with `PMAC_VERIFY_ERRCNT_EN`.

## Operation
- A transfer occurs on any interface when val and rdy are both high on a rising edge.
- FSM states: IDLE, ISSUE, STREAM, WAIT_MAC, RESULT.
- IDLE:
  - `vreq_rdy`=1.
  - On accept, register len and tag, clear `beat_cnt`.
  - Next state: ISSUE if len≠0, else RESULT with `res_ok`=0 and `res_len_err`=1. The engine is not touched in the zero-length case.
- ISSUE:
  - `pmac_req_val`=1 and `pmac_req_len`=registered len, both held stable until accepted.
  - On accept, go to STREAM.
- STREAM:
  - Combinational pass-through: `pmac_data`=`in_data`, `pmac_data_val`=`in_val`, `in_rdy`=`pmac_data_rdy`.
  - `beat_cnt` (16 bit) increments per accepted beat.
  - On the beat where `beat_cnt`==len-1, go to WAIT_MAC.
  - `in_rdy` and `pmac_data_val` are 0 in every other state.
- WAIT_MAC:
  - `pmac_tag_rdy`=1.
  - On accept, register `res_ok` = (`pmac_tag` == stored tag), compared over the full 128 bits with no early-out. Set `res_len_err`=0 and go to RESULT.
- RESULT:
  - `res_val`=1; `res_ok` and `res_len_err` are held stable.
  - On accept, return to IDLE.
- Only one request is in flight at a time; `vreq_rdy`=0 outside IDLE.

## Timing
- Reset values:
  - State IDLE, `beat_cnt`=0.
  - `vreq_rdy`=1; all other val/rdy outputs 0.
  - `res_ok`=0, `res_len_err`=0, `pmac_req_len`=0, `err_cnt`=0.
- `pmac_data`, `pmac_data_val` and `in_rdy` are zero-latency combinational paths in STREAM.
- Request accept to `pmac_req_val` high: 1 cycle.
- Tag accept to `res_val` high: 1 cycle.
- Zero-length request: `res_val` high 1 cycle after accept.
- Result back-pressure is held indefinitely; nothing is dropped.
- `vreq_len`=65535 is supported (16-bit counter, no wrap before terminal compare).
- Reset mid-operation: all state is cleared immediately. The team's contract is that `pmac` shares `rst_n`, so no engine transaction is left dangling.
- Back-to-back requests: `vreq_rdy` reasserts the cycle after result accept (IDLE), giving a minimum 1-cycle gap.

## Configuration
- `PMAC_VERIFY_ERRCNT_EN` defined:
  - Adds port `err_cnt` (32 bit, saturating at 0xFFFFFFFF).
  - Increments on each accepted result with `res_ok`=0, including zero-length errors.
  - Cleared only by reset.
- Not defined: no `err_cnt` port and no counter logic; all other behaviour is identical.

## Test plan
- Single beat, pass: data=0, len=1, tag=a68da5fae5cc2840298cd0d5f24677e9, with `pmac` attached → `res_val` with `res_ok`=1, `res_len_err`=0.
- Single beat, fail: same as above but tag LSB flipped (…77e8) → `res_ok`=0; `err_cnt`=1 when enabled.
- Multi-beat with back-pressure:
  - Stimulus: data base 0x00010203…3e3f + i for i=0..63, len=64, tag=1cc41049fab379e5091ef94e2e3233c9.
  - Random `in_val` gaps and random `pmac_data_rdy` stalls.
  - Required: `res_ok`=1, exactly 64 beats forwarded, `pmac_req_len`=64.
- Zero length: len=0 → no `pmac_req_val` pulse; `res_val` 1 cycle later with `res_ok`=0, `res_len_err`=1.
- Result stall and back-to-back:
  - Hold `res_rdy`=0 for 10 cycles → `res_val`/`res_ok` stay stable.
  - Then a second request (len=2, data base as above, tag=7b40e19daaff678585571c90c0490047) → `res_ok`=1.
- Reset mid-stream: assert `rst_n`=0 after 3 of 8 beats → all outputs at reset values. A fresh len=4 request (tag=e837386444e93062ff1021792b2db592) then passes.

Source files
------------

// File: rtl/pmac_verify.sv
// Verify wrapper around a pmac engine: issues the length request, forwards the
// data stream, compares the returned MAC with the expected tag. Optional error
// counter is enabled by defining PMAC_VERIFY_ERRCNT_EN.
module pmac_verify #(
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vreq_val,
    output logic                  vreq_rdy,
    input  logic [15:0]           vreq_len,
    input  logic [TAG_WIDTH-1:0]  vreq_tag,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic                  pmac_req_val,
    input  logic                  pmac_req_rdy,
    output logic [15:0]           pmac_req_len,
    output logic [DATA_WIDTH-1:0] pmac_data,
    output logic                  pmac_data_val,
    input  logic                  pmac_data_rdy,
    input  logic [TAG_WIDTH-1:0]  pmac_tag,
    input  logic                  pmac_tag_val,
    output logic                  pmac_tag_rdy,
    output logic                  res_val,
    input  logic                  res_rdy,
    output logic                  res_ok,
`ifdef PMAC_VERIFY_ERRCNT_EN
    output logic [31:0]           err_cnt,
`endif
    output logic                  res_len_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_STREAM,
        S_WAIT_MAC,
        S_RESULT
    } state_t;

    state_t               r_state;
    logic                 r_vreq_rdy;
    logic                 r_pmac_req_val;
    logic                 r_pmac_tag_rdy;
    logic                 r_res_val;
    logic                 r_res_ok;
    logic                 r_res_len_err;
    logic [15:0]          r_len;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [15:0]          r_beat_cnt;

    logic w_stream;
    logic w_beat;
    logic w_last;

    // The data path is a pure pass-through; only the handshakes are gated by state.
    assign w_stream      = (r_state == S_STREAM);
    assign pmac_data     = in_data;
    assign pmac_data_val = w_stream & in_val;
    assign in_rdy        = w_stream & pmac_data_rdy;
    assign w_beat        = w_stream & in_val & pmac_data_rdy;
    assign w_last        = (r_beat_cnt == r_len - 16'd1);

    assign vreq_rdy     = r_vreq_rdy;
    assign pmac_req_val = r_pmac_req_val;
    assign pmac_req_len = r_len;
    assign pmac_tag_rdy = r_pmac_tag_rdy;
    assign res_val      = r_res_val;
    assign res_ok       = r_res_ok;
    assign res_len_err  = r_res_len_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_vreq_rdy     <= 1'b1;
            r_pmac_req_val <= 1'b0;
            r_pmac_tag_rdy <= 1'b0;
            r_res_val      <= 1'b0;
            r_res_ok       <= 1'b0;
            r_res_len_err  <= 1'b0;
            r_len          <= '0;
            // NOTE: the stored tag is reset as well so no stale tag survives a mid-operation reset.
            r_tag          <= '0;
            r_beat_cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (vreq_val) begin
                        r_len      <= vreq_len;
                        r_tag      <= vreq_tag;
                        r_beat_cnt <= '0;
                        r_vreq_rdy <= 1'b0;
                        if (vreq_len != 16'd0) begin
                            r_pmac_req_val <= 1'b1;
                            r_state        <= S_ISSUE;
                        end else begin
                            r_res_ok      <= 1'b0;
                            r_res_len_err <= 1'b1;
                            r_res_val     <= 1'b1;
                            r_state       <= S_RESULT;
                        end
                    end
                end
                S_ISSUE: begin
                    if (pmac_req_rdy) begin
                        r_pmac_req_val <= 1'b0;
                        r_state        <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 16'd1;
                        if (w_last) begin
                            r_pmac_tag_rdy <= 1'b1;
                            r_state        <= S_WAIT_MAC;
                        end
                    end
                end
                S_WAIT_MAC: begin
                    if (pmac_tag_val) begin
                        r_res_ok       <= (pmac_tag == r_tag);
                        r_res_len_err  <= 1'b0;
                        r_pmac_tag_rdy <= 1'b0;
                        r_res_val      <= 1'b1;
                        r_state        <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_rdy) begin
                        r_res_val  <= 1'b0;
                        r_vreq_rdy <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PMAC_VERIFY_ERRCNT_EN
    logic [31:0] r_err_cnt;

    // Counts every failed result, zero-length errors included, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (r_res_val && res_rdy && !r_res_ok && (r_err_cnt != 32'hFFFF_FFFF)) begin
            r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
